// File: rtl/fir_decim_sink_if.sv
// fir_decim_sink_if: the sample stream from the FIR, plus the decimated output
// stream and its status/control signals.
//   x_t/x_valid                 : FIR sample stream (no backpressure)
//   dout/dout_valid/dout_ready  : decimated output, valid/ready handshake
//   count                       : FIFO occupancy, 0..DEPTH
//   ovf/clear_ovf               : sticky drop flag and its synchronous clear
// slave  = the decimator side; master = the FIR/downstream environment side.
interface fir_decim_sink_if #(
  parameter int DEPTH = 4
);
  logic signed [15:0]       x_t;
  logic                     x_valid;
  logic signed [15:0]       dout;
  logic                     dout_valid;
  logic                     dout_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf;
  logic                     clear_ovf;

  modport slave (
    input  x_t, x_valid, dout_ready, clear_ovf,
    output dout, dout_valid, count, ovf
  );

  modport master (
    output x_t, x_valid, dout_ready, clear_ovf,
    input  dout, dout_valid, count, ovf
  );
endinterface

// File: rtl/fir_decim_sink.sv
// fir_decim_sink: boxcar-averaging decimator on the FIR output stream.
// Every DECIM valid samples are summed and divided by DECIM (arithmetic shift,
// rounding toward -inf). The result is pushed into a DEPTH-entry FIFO that is
// drained over a valid/ready handshake. A result that finds the FIFO full
// (and no pop on the same edge) is dropped and sets the sticky ovf flag.
//   system1000       : clock, rising edge
//   system1000_rstn  : asynchronous active-low reset
//   bus              : fir_decim_sink_if.slave (stream in, stream out, status)
module fir_decim_sink #(
  parameter int DECIM      = 4,
  parameter int LOG2_DECIM = 2,
  parameter int DEPTH      = 4
)(
  input  logic             system1000,
  input  logic             system1000_rstn,
  fir_decim_sink_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = 16 + LOG2_DECIM;

  logic [LOG2_DECIM-1:0] ph;
  logic signed [SW-1:0]  acc;
  logic signed [SW-1:0]  sum;
  logic signed [15:0]    result;
  logic signed [15:0]    mem [DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf_q;
  logic                  blk_end, pop, push, drop, full, not_empty;

  always_comb begin
    sum       = acc + {{LOG2_DECIM{bus.x_t[15]}}, bus.x_t};
    // Dropping the low LOG2_DECIM bits of the two's-complement sum is the
    // arithmetic right shift; the sum of DECIM 16-bit samples always fits
    // in SW bits, so the upper 16 bits are the exact floor average.
    result    = sum[SW-1:LOG2_DECIM];
    blk_end   = bus.x_valid && (ph == LOG2_DECIM'(DECIM - 1));
    not_empty = (cnt != '0);
    full      = (cnt == CW'(DEPTH));
    pop       = not_empty && bus.dout_ready;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    push      = blk_end && (!full || pop);
    drop      = blk_end && !push;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      ph     <= '0;
      acc    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.x_valid) begin
        if (blk_end) begin
          ph  <= '0;
          acc <= '0;
        end else begin
          ph  <= ph + 1'b1;
          acc <= sum;
        end
      end
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      // Setting wins over a same-cycle clear so no drop is ever lost.
      if (drop)               ovf_q <= 1'b1;
      else if (bus.clear_ovf) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
  always_ff @(posedge system1000) begin
    if (push) mem[wr_ptr] <= result;
  end

  assign bus.dout_valid = not_empty;
  assign bus.dout       = not_empty ? mem[rd_ptr] : '0;
  assign bus.count      = cnt;
  assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_fir_decim_sink.sv
// tb_fir_decim_sink: scoreboard bench for fir_decim_sink (DECIM=4, DEPTH=4).
// A reference model at each rising edge collects samples into blocks, takes
// the floor average with integer division, tracks FIFO occupancy and the
// sticky drop flag, and queues accepted results. A monitor on the falling
// edge compares the DUT's outputs against the model and the queue head, and
// logs every handshaken value so directed scenarios can check them.
module tb_fir_decim_sink;
  localparam int DECIM = 4;
  localparam int LOG2_DECIM = 2;
  localparam int DEPTH = 4;

  logic system1000 = 1'b0;
  logic system1000_rstn = 1'b0;
  always #5 system1000 = ~system1000;

  fir_decim_sink_if #(.DEPTH(DEPTH)) bus();

  fir_decim_sink #(.DECIM(DECIM), .LOG2_DECIM(LOG2_DECIM), .DEPTH(DEPTH)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .bus             (bus)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int blk[$];
  int exp_q[$];
  int seen[$];
  int mocc = 0;
  int movf = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int floor_avg(input int s);
    int r;
    r = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) r = r - 1;
    return r;
  endfunction

  always @(posedge system1000) begin
    if (system1000_rstn) begin
      int s;
      bit done;
      bit pop_m;
      bit drop;
      done  = 0;
      drop  = 0;
      s     = 0;
      pop_m = (mocc > 0) && bus.dout_ready;
      if (bus.x_valid) begin
        blk.push_back(int'(bus.x_t));
        if (blk.size() == DECIM) begin
          foreach (blk[i]) s += blk[i];
          blk.delete();
          done = 1;
        end
      end
      if (pop_m) mocc--;
      if (done) begin
        if (mocc < DEPTH) begin
          exp_q.push_back(floor_avg(s));
          mocc++;
        end else begin
          drop = 1;
        end
      end
      if (drop) movf = 1;
      else if (bus.clear_ovf) movf = 0;
    end
  end

  always @(negedge system1000) begin
    if (system1000_rstn) begin
      chk("count", int'(bus.count), mocc);
      chk("dout_valid", int'(bus.dout_valid), int'(mocc > 0));
      chk("ovf", int'(bus.ovf), movf);
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_has_entry", exp_q.size(), 1);
        end else begin
          chk("dout", int'(bus.dout), exp_q[0]);
          if (bus.dout_ready) begin
            seen.push_back(int'(bus.dout));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("dout_idle", int'(bus.dout), 0);
      end
    end
  end

  // Inputs change 1 ns after the rising edge and hold for a full cycle.
  task automatic step(input bit v, input int x, input bit rdy, input bit clr);
    bus.x_valid    = v;
    bus.x_t        = 16'(x);
    bus.dout_ready = rdy;
    bus.clear_ovf  = clr;
    @(posedge system1000);
    #1;
  endtask

  task automatic blk4(input int a, input int b, input int c, input int d, input bit rdy);
    step(1, a, rdy, 0);
    step(1, b, rdy, 0);
    step(1, c, rdy, 0);
    step(1, d, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy, 0);
  endtask

  initial begin
    bus.x_valid = 0; bus.x_t = 0; bus.dout_ready = 0; bus.clear_ovf = 0;
    #3;
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_dout", int'(bus.dout), 0);
    repeat (2) @(posedge system1000);
    #1;
    system1000_rstn = 1;

    // basic average: result one cycle after the last sample, then empty
    seen.delete();
    step(1, 100, 1, 0);
    step(1, 200, 1, 0);
    step(1, 300, 1, 0);
    step(1, 400, 1, 0);
    chk("basic_latency_valid", int'(bus.dout_valid), 1);
    chk("basic_latency_dout", int'(bus.dout), 250);
    idle(1, 1);
    chk("basic_after_valid", int'(bus.dout_valid), 0);
    chk("basic_n", seen.size(), 1);
    if (seen.size() >= 1) chk("basic_val", seen[0], 250);

    // rounding and extremes
    seen.delete();
    blk4(-1, -1, -1, -2, 1);
    blk4(32767, 32767, 32767, 32767, 1);
    blk4(-32768, -32768, -32768, -32768, 1);
    blk4(1, 0, 0, 0, 1);
    idle(2, 1);
    chk("round_n", seen.size(), 4);
    if (seen.size() == 4) begin
      chk("round_neg", seen[0], -2);
      chk("round_max", seen[1], 32767);
      chk("round_min", seen[2], -32768);
      chk("round_small", seen[3], 0);
    end

    // gapped input
    seen.delete();
    step(1, 10, 1, 0);
    idle(3, 1);
    step(1, 20, 1, 0);
    step(1, 30, 1, 0);
    idle(1, 1);
    chk("gap_no_early", int'(bus.dout_valid), 0);
    step(1, 40, 1, 0);
    chk("gap_dout", int'(bus.dout), 25);
    idle(2, 1);
    chk("gap_n", seen.size(), 1);
    if (seen.size() >= 1) chk("gap_val", seen[0], 25);

    // backpressure and overflow
    seen.delete();
    for (int k = 1; k <= 5; k++) blk4(k, k, k, k, 0);
    chk("bp_count", int'(bus.count), 4);
    chk("bp_ovf", int'(bus.ovf), 1);
    idle(6, 1);
    chk("bp_n", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("bp_order", seen[i], i + 1);
    step(0, 0, 1, 1);
    chk("bp_clear", int'(bus.ovf), 0);

    // full with simultaneous pop on the block-end edge
    seen.delete();
    for (int k = 6; k <= 9; k++) blk4(k, k, k, k, 0);
    step(1, 10, 0, 0);
    step(1, 10, 0, 0);
    step(1, 10, 0, 0);
    step(1, 10, 1, 0);
    chk("fullpop_count", int'(bus.count), 4);
    chk("fullpop_ovf", int'(bus.ovf), 0);
    idle(6, 1);
    chk("fullpop_n", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("fullpop_order", seen[i], i + 6);

    // reset mid-operation: two entries queued plus a partial block
    blk4(11, 11, 11, 11, 0);
    blk4(12, 12, 12, 12, 0);
    step(1, 100, 0, 0);
    step(1, 200, 0, 0);
    chk("pre_rst_count", int'(bus.count), 2);
    bus.x_valid = 0;
    #2;
    system1000_rstn = 0;
    #1;
    chk("mid_rst_valid", int'(bus.dout_valid), 0);
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_ovf", int'(bus.ovf), 0);
    chk("mid_rst_dout", int'(bus.dout), 0);
    blk.delete(); exp_q.delete(); mocc = 0; movf = 0;
    #10;
    system1000_rstn = 1;
    @(posedge system1000);
    #1;
    seen.delete();
    blk4(8, 8, 8, 8, 1);
    idle(2, 1);
    chk("post_rst_n", seen.size(), 1);
    if (seen.size() >= 1) chk("post_rst_val", seen[0], 8);

    // randomized traffic, first half with heavy backpressure
    for (int c = 0; c < 1500; c++) begin
      int x;
      bit rdy;
      case ($urandom_range(0, 9))
        0:       x = 32767;
        1:       x = -32768;
        default: x = int'($signed(16'($urandom)));
      endcase
      rdy = (c < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 4) != 0, x, rdy, $urandom_range(0, 15) == 0);
    end
    idle(20, 1);
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_decim_sink.md
# fir_decim_sink

Consumer end of the FIR sample stream: accepts the filter's signed 16-bit output samples and decimates them by a fixed power-of-two factor using boxcar averaging. It buffers the decimated results in a small FIFO and hands them to downstream logic over a valid/ready handshake. The block sits directly after the FIR top entity in the `system1000` clock domain and is the reader for the filter's writer.

## Interface
- `DECIM`, 4: decimation factor; power of two, 2..16.
- `LOG2_DECIM`, 2: log2(`DECIM`); must match `DECIM`.
- `DEPTH`, 4: output FIFO depth in entries; power of two, 2..16.
- `system1000`  in  1  clock; all state updates on the rising edge.
- `system1000_rstn`  in  1  reset; asynchronous, active-low.
- `x_t`  in  16  signed sample from the FIR output.
- `x_valid`  in  1  `x_t` is a valid sample this cycle; there is no backpressure toward the FIR.
- `dout`  out  16  signed decimated sample at the FIFO head; reads 0 whenever `dout_valid`=0.
- `dout_valid`  out  1  FIFO is non-empty.
- `dout_ready`  in  1  downstream accepts `dout`.
- `count`  out  LOG2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `ovf`  out  1  sticky flag: a decimated result was dropped.
- `clear_ovf`  in  1  synchronous clear of `ovf`.

## Operation
- **State**
  - phase counter `ph`, 0..DECIM-1.
  - signed accumulator `acc`, 16+LOG2_DECIM bits.
  - FIFO: read pointer, write pointer, occupancy counter.
  - `ovf` register.
- **Accumulate.** When `x_valid`=1 and `ph`<DECIM-1: `acc` <= `acc` + sext(`x_t`) and `ph` increments. When `x_valid`=0, `acc` and `ph` hold; gaps are allowed anywhere.
- **Block end.** When `x_valid`=1 and `ph`=DECIM-1:
  - sum = `acc` + sext(`x_t`).
  - result = sum >>> LOG2_DECIM, arithmetic shift, rounds toward −inf. The result always fits in 16 bits, so there is no saturation.
  - push the result, then `acc` <= 0 and `ph` <= 0.
- **Push rules.**
  - Accepted if `count`<DEPTH, or if a pop occurs in the same cycle (pop is evaluated first).
  - Otherwise the result is dropped, `ovf` <= 1, and FIFO contents are unchanged.
- **Pop.** Occurs when `dout_valid`=1 and `dout_ready`=1; the read pointer advances.
- **Occupancy.** Push only: +1. Pop only: −1. Both: unchanged. Pointers wrap modulo DEPTH.
- **`ovf`.** Set has priority over `clear_ovf` when both occur in the same cycle.
- **Handshake.**
  - `dout` must stay stable while `dout_valid`=1 and `dout_ready`=0.
  - `dout_ready` is ignored when `dout_valid`=0.
  - FIFO order is strictly first-in first-out.
- **Reset (asynchronous, any time, including mid-block).**
  - `acc`=0, `ph`=0, pointers=0, `count`=0, `ovf`=0.
  - Outputs: `dout`=0, `dout_valid`=0.
  - A partially accumulated block is discarded. The first valid sample after reset release begins a new block.

## Timing
- The block-end sample is sampled at edge k. If a push occurs, `dout_valid`=1 and `dout`=result in cycle k+1. Latency is 1 cycle from the last sample of a block.
- Pop at edge k: the next entry, or `dout_valid`=0 if the FIFO is now empty, appears in cycle k+1.
- Push into a full FIFO with a simultaneous pop: accepted, `count` stays DEPTH, no `ovf`.
- Push into an empty FIFO: there is no bypass path; `dout_valid` rises the following cycle.
- `ovf` rises in the cycle after the dropping edge.
- `count` and `dout_valid` are registered or derived only from registers. There is no combinational path from `dout_ready` to `dout_valid`.
- At steady rate with `x_valid`=1 every cycle and `dout_ready`=1: one output every DECIM cycles, `count` ≤1, no drops.

## Test plan
All scenarios use default parameters (`DECIM`=4, `DEPTH`=4).
- **Basic average.** `x_t`=100,200,300,400 on consecutive valid cycles, `dout_ready`=1 → `dout`=250 for one cycle, one cycle after the 400 sample; then `dout_valid`=0.
- **Rounding and extremes.**
  - Block −1,−1,−1,−2 → `dout`=−2 (−5>>>2).
  - Block 32767×4 → 32767.
  - Block −32768×4 → −32768.
  - Block 1,0,0,0 → 0.
- **Gapped input.** 10,`x_valid`=0 ×3,20,30,`x_valid`=0,40 → `dout`=25 one cycle after the 40 sample; `ph` holds across gaps.
- **Backpressure and overflow.**
  - Stimulus: `dout_ready`=0, five blocks of constant values 1,2,3,4,5.
  - Required: `count`=4, `ovf`=1 after the 5th block.
  - Then `dout_ready`=1 → outputs 1,2,3,4 in order; value 5 never appears.
  - Then `clear_ovf` pulse → `ovf`=0.
- **Full with simultaneous pop.** FIFO holds 4 entries; `dout_ready`=1 on the exact cycle a 5th block ends → no drop, `ovf` stays 0, `count` stays 4, and all 5 values emerge in order.
- **Reset mid-operation.**
  - Stimulus: feed 100,200; assert `system1000_rstn`=0 asynchronously with FIFO holding 2 entries; release.
  - Required: `dout_valid`=0, `count`=0, `ovf`=0, `dout`=0 immediately on reset assertion.
  - Then 8,8,8,8 → `dout`=8, with the earlier partial samples discarded.
